// File: rtl/srio_dstream_reassembler.sv
// Reassembles SRIO Type 9 data-streaming segments into PDUs on an AXI4-Stream master.
// Header beats are consumed internally; an aborted PDU is closed with an empty TLAST terminator beat.
module srio_dstream_reassembler #(
    parameter int CHECK_LEN = 1
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic [63:0] S_AXIS_TDATA,
    input  logic [7:0]  S_AXIS_TKEEP,
    input  logic        S_AXIS_TLAST,
    input  logic [31:0] S_AXIS_TUSER,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    output logic [63:0] M_AXIS_TDATA,
    output logic [7:0]  M_AXIS_TKEEP,
    output logic        M_AXIS_TLAST,
    output logic [31:0] M_AXIS_TUSER,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [15:0] STAT_PDU_CNT,
    output logic [15:0] STAT_ERR_CNT,
    output logic [3:0]  ERR_PULSE
);
    typedef enum logic [1:0] {HDR, DATA, DISCARD, TERM} state_t;

    function automatic logic [3:0] popcnt8(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, k[i]};
        return n;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q, state_d, ret_q, ret_d, target;
    logic        in_pdu_q, in_pdu_d, lat_e_q, lat_e_d, abort;
    logic [15:0] lat_sid_q, lat_sid_d, lat_len_q, lat_len_d;
    logic [31:0] lat_tuser_q, lat_tuser_d, term_tuser_q, term_tuser_d;
    logic [16:0] byte_cnt_q, byte_cnt_d, exp_len;
    logic [3:0]  err_d, err_q;
    logic [15:0] pdu_cnt_q, err_cnt_q;
    logic        pdu_done, slot_free, s_ready, acc;
    logic        load_p0, tlast_p0;
    logic [63:0] tdata_p0;
    logic [7:0]  tkeep_p0;
    logic [31:0] tuser_p0;
    logic        vld_p1, tlast_p1;
    logic [63:0] tdata_p1;
    logic [7:0]  tkeep_p1;
    logic [31:0] tuser_p1;

    // Header field decode
    logic        hdr_s, hdr_e, hdr_fmt_bad;
    logic [15:0] hdr_sid, hdr_len;
    assign hdr_s       = S_AXIS_TDATA[51];
    assign hdr_e       = S_AXIS_TDATA[50];
    assign hdr_sid     = S_AXIS_TDATA[47:32];
    assign hdr_len     = S_AXIS_TDATA[31:16];
    assign hdr_fmt_bad = (S_AXIS_TDATA[55:52] != 4'd9) || S_AXIS_TLAST;
    assign exp_len     = (lat_len_q == 16'd0) ? 17'h10000 : {1'b0, lat_len_q};

    assign slot_free = !vld_p1 || M_AXIS_TREADY;
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            HDR, DISCARD: s_ready = 1'b1;
            DATA:         s_ready = slot_free;
            default:      s_ready = 1'b0;
        endcase
    end
    assign S_AXIS_TREADY = AXIS_ARESETN && s_ready;
    assign acc = S_AXIS_TVALID && S_AXIS_TREADY;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        in_pdu_d     = in_pdu_q;
        lat_e_d      = lat_e_q;
        lat_sid_d    = lat_sid_q;
        lat_len_d    = lat_len_q;
        lat_tuser_d  = lat_tuser_q;
        term_tuser_d = term_tuser_q;
        byte_cnt_d   = byte_cnt_q;
        err_d        = 4'd0;
        pdu_done     = 1'b0;
        abort        = 1'b0;
        target       = DATA;
        load_p0      = 1'b0;
        tdata_p0     = 64'd0;
        tkeep_p0     = 8'd0;
        tlast_p0     = 1'b0;
        tuser_p0     = 32'd0;
        case (state_q)
            HDR: if (acc) begin
                if (hdr_fmt_bad) begin
                    err_d[3] = 1'b1;
                    abort    = in_pdu_q;
                    target   = S_AXIS_TLAST ? HDR : DISCARD;
                end else if (!hdr_s && !in_pdu_q) begin
                    err_d[2] = 1'b1;
                    target   = DISCARD;
                end else if (hdr_s && in_pdu_q) begin
                    err_d[2] = 1'b1;
                    abort    = 1'b1;
                end else if (!hdr_s && hdr_sid != lat_sid_q) begin
                    err_d[1] = 1'b1;
                    abort    = 1'b1;
                    target   = DISCARD;
                end
                if (abort) in_pdu_d = 1'b0;
                if (target == DATA) begin
                    lat_e_d   = hdr_e;
                    lat_len_d = hdr_len;
                    if (hdr_s) begin
                        lat_sid_d   = hdr_sid;
                        lat_tuser_d = S_AXIS_TUSER;
                        byte_cnt_d  = 17'd0;
                        in_pdu_d    = 1'b1;
                    end
                end
                // Terminator carries the aborted PDU's TUSER, even if a new PDU starts here
                if (abort) begin
                    term_tuser_d = lat_tuser_q;
                    ret_d        = target;
                    state_d      = TERM;
                end else begin
                    state_d = target;
                end
            end
            DATA: if (acc) begin
                load_p0    = 1'b1;
                tdata_p0   = S_AXIS_TDATA;
                tkeep_p0   = S_AXIS_TKEEP;
                tlast_p0   = S_AXIS_TLAST && lat_e_q;
                tuser_p0   = lat_tuser_q;
                byte_cnt_d = byte_cnt_q + {13'd0, popcnt8(S_AXIS_TKEEP)};
                if (S_AXIS_TLAST) begin
                    state_d = HDR;
                    if (lat_e_q) begin
                        in_pdu_d = 1'b0;
                        pdu_done = 1'b1;
                        if (CHECK_LEN != 0 && byte_cnt_d != exp_len) err_d[0] = 1'b1;
                    end
                end
            end
            DISCARD: if (acc && S_AXIS_TLAST) state_d = HDR;
            TERM: if (slot_free) begin
                load_p0  = 1'b1;
                tlast_p0 = 1'b1;
                tuser_p0 = term_tuser_q;
                state_d  = ret_q;
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q      <= HDR;
            ret_q        <= HDR;
            in_pdu_q     <= 1'b0;
            lat_e_q      <= 1'b0;
            lat_sid_q    <= 16'd0;
            lat_len_q    <= 16'd0;
            lat_tuser_q  <= 32'd0;
            term_tuser_q <= 32'd0;
            byte_cnt_q   <= 17'd0;
            err_q        <= 4'd0;
            pdu_cnt_q    <= 16'd0;
            err_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            in_pdu_q     <= in_pdu_d;
            lat_e_q      <= lat_e_d;
            lat_sid_q    <= lat_sid_d;
            lat_len_q    <= lat_len_d;
            lat_tuser_q  <= lat_tuser_d;
            term_tuser_q <= term_tuser_d;
            byte_cnt_q   <= byte_cnt_d;
            err_q        <= err_d;
            if (pdu_done) pdu_cnt_q <= pdu_cnt_q + 16'd1;
            if (err_d != 4'd0) err_cnt_q <= sat_inc16(err_cnt_q);
        end
    end

    // Output register stage (p0 -> p1)
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            vld_p1   <= 1'b0;
            tdata_p1 <= 64'd0;
            tkeep_p1 <= 8'd0;
            tlast_p1 <= 1'b0;
            tuser_p1 <= 32'd0;
        end else if (load_p0) begin
            vld_p1   <= 1'b1;
            tdata_p1 <= tdata_p0;
            tkeep_p1 <= tkeep_p0;
            tlast_p1 <= tlast_p0;
            tuser_p1 <= tuser_p0;
        end else if (M_AXIS_TREADY) begin
            vld_p1 <= 1'b0;
        end
    end

    assign M_AXIS_TVALID = vld_p1;
    assign M_AXIS_TDATA  = tdata_p1;
    assign M_AXIS_TKEEP  = tkeep_p1;
    assign M_AXIS_TLAST  = tlast_p1;
    assign M_AXIS_TUSER  = tuser_p1;
    assign STAT_PDU_CNT  = pdu_cnt_q;
    assign STAT_ERR_CNT  = err_cnt_q;
    assign ERR_PULSE     = err_q;
endmodule

// File: tb/tb_srio_dstream_reassembler.sv
// Directed bench: a cycle table of segment beats with hand-computed outputs, plus backpressure and reset sequences.
module tb_srio_dstream_reassembler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic [31:0] s_tuser = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready, s_tready2;
    logic [63:0] m_tdata, m_tdata2;
    logic [7:0]  m_tkeep, m_tkeep2;
    logic        m_tlast, m_tlast2, m_tvalid, m_tvalid2;
    logic [31:0] m_tuser, m_tuser2;
    logic        m_tready = 1'b1;
    logic [15:0] pdu_cnt, err_cnt, pdu_cnt2, err_cnt2;
    logic [3:0]  err_pulse, err_pulse2;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    srio_dstream_reassembler #(.CHECK_LEN(1)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TLAST(s_tlast),
        .S_AXIS_TUSER(s_tuser), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TLAST(m_tlast),
        .M_AXIS_TUSER(m_tuser), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
        .STAT_PDU_CNT(pdu_cnt), .STAT_ERR_CNT(err_cnt), .ERR_PULSE(err_pulse)
    );

    srio_dstream_reassembler #(.CHECK_LEN(0)) dut_nolen (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TLAST(s_tlast),
        .S_AXIS_TUSER(s_tuser), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready2),
        .M_AXIS_TDATA(m_tdata2), .M_AXIS_TKEEP(m_tkeep2), .M_AXIS_TLAST(m_tlast2),
        .M_AXIS_TUSER(m_tuser2), .M_AXIS_TVALID(m_tvalid2), .M_AXIS_TREADY(m_tready),
        .STAT_PDU_CNT(pdu_cnt2), .STAT_ERR_CNT(err_cnt2), .ERR_PULSE(err_pulse2)
    );

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [31:0] u;
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        el;
        logic [31:0] eu;
        logic [3:0]  eerr;
        logic [15:0] epdu;
        logic [15:0] eecnt;
        logic        esr;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] U1 = 32'h0011_0022;
    localparam logic [31:0] U2 = 32'h0033_0044;
    localparam logic [31:0] U3 = 32'h0055_0066;

    function automatic logic [63:0] hdr(input logic [3:0] ft, input logic s, input logic e,
                                        input logic [15:0] sid, input logic [15:0] len);
        return {8'h00, ft, s, e, 2'b00, sid, len, 16'h0000};
    endfunction

    task automatic add(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l,
                       input logic [31:0] u, input logic ev, input logic [63:0] ed,
                       input logic [7:0] ek, input logic el, input logic [31:0] eu,
                       input logic [3:0] eerr, input logic [15:0] epdu, input logic [15:0] eecnt,
                       input logic esr);
        vec_t t;
        t = '{v, d, k, l, u, ev, ed, ek, el, eu, eerr, epdu, eecnt, esr};
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k,
                         input logic l, input logic [31:0] u);
        s_tvalid = v;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
    endtask

    logic [63:0] bp_d[5];
    logic [7:0]  bp_k[5];
    logic        bp_l[5];
    logic [31:0] bp_u[5];
    logic [63:0] got_d[$];
    logic        got_l[$];
    logic [31:0] got_u[$];

    initial begin
        // Reset state
        #2;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_pdu_cnt", pdu_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_pulse", err_pulse, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single segment S=E=1, sid 5, 20 bytes
        add(1, hdr(9,1,1,5,20), 8'hFF, 0, U1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 64'hA1A1_0000_0000_0001, 8'hFF, 0, 0, 1, 64'hA1A1_0000_0000_0001, 8'hFF, 0, U1, 0, 0, 0, 1);
        add(1, 64'hA1A1_0000_0000_0002, 8'hFF, 0, 0, 1, 64'hA1A1_0000_0000_0002, 8'hFF, 0, U1, 0, 0, 0, 1);
        add(1, 64'hA1A1_0000_0000_0003, 8'h0F, 1, 0, 1, 64'hA1A1_0000_0000_0003, 8'h0F, 1, U1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        // Continuation at idle: seq error, segment dropped
        add(1, hdr(9,0,0,3,0), 8'hFF, 0, U2, 0, 0, 0, 0, 0, 4'b0100, 1, 1, 1);
        add(1, 64'hDEAD_0000_0000_0004, 8'hFF, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        // Bad ftype with TLAST on the header beat
        add(1, hdr(5,1,1,3,8), 8'hFF, 1, U2, 0, 0, 0, 0, 0, 4'b1000, 1, 2, 1);
        // Mid-PDU S=1 header: terminator, then new PDU intact
        add(1, hdr(9,1,0,7,0), 8'hFF, 0, U2, 0, 0, 0, 0, 0, 0, 1, 2, 1);
        add(1, 64'hB2B2_0000_0000_0001, 8'hFF, 1, 0, 1, 64'hB2B2_0000_0000_0001, 8'hFF, 0, U2, 0, 1, 2, 1);
        add(1, hdr(9,1,1,9,16), 8'hFF, 0, U3, 0, 0, 0, 0, 0, 4'b0100, 1, 3, 0);
        add(0, 0, 0, 0, 0, 1, 0, 8'h00, 1, U2, 0, 1, 3, 1);
        add(1, 64'hC3C3_0000_0000_0001, 8'hFF, 0, 0, 1, 64'hC3C3_0000_0000_0001, 8'hFF, 0, U3, 0, 1, 3, 1);
        add(1, 64'hC3C3_0000_0000_0002, 8'hFF, 1, 0, 1, 64'hC3C3_0000_0000_0002, 8'hFF, 1, U3, 0, 2, 3, 1);
        // Length mismatch: 16 bytes against pdu_length 24
        add(1, hdr(9,1,1,4,24), 8'hFF, 0, U1, 0, 0, 0, 0, 0, 0, 2, 3, 1);
        add(1, 64'hD4D4_0000_0000_0001, 8'hFF, 0, 0, 1, 64'hD4D4_0000_0000_0001, 8'hFF, 0, U1, 0, 2, 3, 1);
        add(1, 64'hD4D4_0000_0000_0002, 8'hFF, 1, 0, 1, 64'hD4D4_0000_0000_0002, 8'hFF, 1, U1, 4'b0001, 3, 4, 1);
        // Stream id mismatch on continuation: terminator, then discard
        add(1, hdr(9,1,0,6,0), 8'hFF, 0, U2, 0, 0, 0, 0, 0, 0, 3, 4, 1);
        add(1, 64'hE5E5_0000_0000_0001, 8'hFF, 1, 0, 1, 64'hE5E5_0000_0000_0001, 8'hFF, 0, U2, 0, 3, 4, 1);
        add(1, hdr(9,0,1,8,8), 8'hFF, 0, U3, 0, 0, 0, 0, 0, 4'b0010, 3, 5, 0);
        add(0, 0, 0, 0, 0, 1, 0, 8'h00, 1, U2, 0, 3, 5, 1);
        add(1, 64'hF6F6_0000_0000_0001, 8'hFF, 1, 0, 0, 0, 0, 0, 0, 0, 3, 5, 1);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].u);
            m_tready = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_tvalid", i), m_tvalid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_tdata", i), m_tdata, tbl[i].ed);
                chk($sformatf("v%0d_tkeep", i), m_tkeep, tbl[i].ek);
                chk($sformatf("v%0d_tlast", i), m_tlast, tbl[i].el);
                chk($sformatf("v%0d_tuser", i), m_tuser, tbl[i].eu);
            end
            chk($sformatf("v%0d_err_pulse", i), err_pulse, tbl[i].eerr);
            chk($sformatf("v%0d_nolen_err_pulse", i), err_pulse2, tbl[i].eerr & 4'b1110);
            chk($sformatf("v%0d_pdu_cnt", i), pdu_cnt, tbl[i].epdu);
            chk($sformatf("v%0d_err_cnt", i), err_cnt, tbl[i].eecnt);
            chk($sformatf("v%0d_s_tready", i), s_tready, tbl[i].esr);
        end

        // Two segments (S then E, sid 7, 24 bytes) under random backpressure
        bp_d[0] = hdr(9,1,0,7,0);        bp_k[0] = 8'hFF; bp_l[0] = 0; bp_u[0] = U1;
        bp_d[1] = 64'h1234_0000_0000_0001; bp_k[1] = 8'hFF; bp_l[1] = 0; bp_u[1] = 0;
        bp_d[2] = 64'h1234_0000_0000_0002; bp_k[2] = 8'hFF; bp_l[2] = 1; bp_u[2] = 0;
        bp_d[3] = hdr(9,0,1,7,24);       bp_k[3] = 8'hFF; bp_l[3] = 0; bp_u[3] = U3;
        bp_d[4] = 64'h1234_0000_0000_0003; bp_k[4] = 8'hFF; bp_l[4] = 1; bp_u[4] = 0;
        begin
            int idx;
            idx = 0;
            for (int cyc = 0; cyc < 300 && (idx < 5 || got_d.size() < 3 || m_tvalid); cyc++) begin
                @(negedge clk);
                m_tready = 1'($urandom_range(0, 1));
                if (idx < 5) drive(1, bp_d[idx], bp_k[idx], bp_l[idx], bp_u[idx]);
                else drive(0, 0, 0, 0, 0);
                #4;
                if (m_tvalid && m_tready) begin
                    got_d.push_back(m_tdata);
                    got_l.push_back(m_tlast);
                    got_u.push_back(m_tuser);
                end
                if (s_tvalid && s_tready) idx++;
            end
            chk("bp_inputs_accepted", idx, 5);
        end
        chk("bp_beat_count", got_d.size(), 3);
        if (got_d.size() == 3) begin
            chk("bp_d0", got_d[0], 64'h1234_0000_0000_0001);
            chk("bp_d1", got_d[1], 64'h1234_0000_0000_0002);
            chk("bp_d2", got_d[2], 64'h1234_0000_0000_0003);
            chk("bp_tlast", {got_l[0], got_l[1], got_l[2]}, 3'b001);
            chk("bp_tuser2", got_u[2], U1);
        end
        chk("bp_err_cnt", err_cnt, 5);
        chk("bp_pdu_cnt", pdu_cnt, 4);

        // Reset mid-DATA with an output beat held
        @(negedge clk);
        m_tready = 1'b0;
        drive(1, hdr(9,1,1,2,16), 8'hFF, 0, U1);
        @(negedge clk);
        drive(1, 64'h7777_0000_0000_0001, 8'hFF, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        chk("pre_rst_tvalid", m_tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", m_tvalid, 0);
        chk("mid_rst_tdata", m_tdata, 0);
        chk("mid_rst_pdu_cnt", pdu_cnt, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_s_tready", s_tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_tready = 1'b1;
        drive(1, hdr(9,1,1,2,8), 8'hFF, 0, U2);
        @(posedge clk);
        #1;
        chk("post_rst_hdr_tvalid", m_tvalid, 0);
        @(negedge clk);
        drive(1, 64'h8888_0000_0000_0001, 8'hFF, 1, 0);
        @(posedge clk);
        #1;
        chk("post_rst_tvalid", m_tvalid, 1);
        chk("post_rst_tdata", m_tdata, 64'h8888_0000_0000_0001);
        chk("post_rst_tlast", m_tlast, 1);
        chk("post_rst_tuser", m_tuser, U2);
        chk("post_rst_pdu_cnt", pdu_cnt, 1);
        chk("post_rst_err_pulse", err_pulse, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
